// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multicycle RV32I core. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB. Handshakes with variable-latency memories.
// Traps on illegal opcodes and memory timeouts, and counts retired instructions.
module multicycle_control_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       OpCode,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic             InstrReady,
  input  logic             MemReady,
  output logic             IMRd,
  output logic             IRWr,
  output logic             PCWr,
  output logic             RUWr,
  output logic             ALUASrc,
  output logic             ALUBSrc,
  output logic [3:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic [4:0]       BrOp,
  output logic             DMRd,
  output logic             DMWr,
  output logic [2:0]       DMCtrl,
  output logic [1:0]       RUDataWrSrc,
  output logic [2:0]       State,
  output logic             Trap,
  output logic [1:0]       TrapCause,
  output logic [CNT_W-1:0] InstRet
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // A wait that has already spent TIMEOUT-1 cycles and still sees no ready traps.
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_JUMP = 5'b10000;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_FETCH   = 2'b10;
  localparam logic [1:0] CAUSE_MEM     = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b111
  } state_t;

  state_t           state, next_state;
  logic [TW-1:0]    wait_cnt;
  logic [6:0]       opcode_q;
  logic [2:0]       funct3_q;
  logic             funct7_5_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] inst_ret_q;

  // Only Funct7[5] carries meaning for RV32I control (SUB/SRA/SRAI).
  logic unused_funct7;
  assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

  logic is_load, is_store, is_branch, is_jump;
  assign is_load   = (opcode_q == OP_LOAD);
  assign is_store  = (opcode_q == OP_STORE);
  assign is_branch = (opcode_q == OP_BRANCH);
  assign is_jump   = (opcode_q == OP_JAL) || (opcode_q == OP_JALR);

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  // The alternate bit only distinguishes ADD/SUB (funct3 000) and SRL/SRA (101).
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    if ((f3 == 3'b000) || (f3 == 3'b101)) arith_op = {alt, f3};
    else                                  arith_op = {1'b0, f3};
  endfunction

  logic       imrd_c, irwr_c, pcwr_c, ruwr_c, dmrd_c, dmwr_c, alu_en;
  logic [2:0] dmctrl_c;
  logic [1:0] rusrc_c;
  logic [4:0] brop_c;
  logic       wait_inc, trap_set;
  logic [1:0] trap_code;
  logic       alu_a_c, alu_b_c;
  logic [3:0] alu_op_c;
  logic [2:0] imm_c;

  // Datapath ALU/immediate selection for the latched instruction.
  always_comb begin
    alu_a_c  = 1'b0;
    alu_b_c  = 1'b0;
    alu_op_c = ALU_ADD;
    imm_c    = IMM_I;
    case (opcode_q)
      OP_R:      alu_op_c = arith_op(funct3_q, funct7_5_q);
      OP_I: begin
        alu_b_c  = 1'b1;
        alu_op_c = arith_op(funct3_q, (funct3_q == 3'b101) && funct7_5_q);
      end
      OP_LOAD:   alu_b_c = 1'b1;
      OP_STORE: begin
        alu_b_c = 1'b1;
        imm_c   = IMM_S;
      end
      OP_BRANCH: begin
        alu_a_c = 1'b1;
        alu_b_c = 1'b1;
        imm_c   = IMM_B;
      end
      OP_JAL: begin
        alu_a_c = 1'b1;
        alu_b_c = 1'b1;
        imm_c   = IMM_J;
      end
      OP_JALR:   alu_b_c = 1'b1;
      OP_LUI: begin
        alu_b_c  = 1'b1;
        imm_c    = IMM_U;
        alu_op_c = ALU_PASS_B;
      end
      OP_AUIPC: begin
        alu_a_c = 1'b1;
        alu_b_c = 1'b1;
        imm_c   = IMM_U;
      end
      default: ;
    endcase
  end

  // Next-state logic and per-state strobes. The ALU controls stay driven from
  // EXEC through MEM/WB because the address, write-back value and jump target
  // are all taken from the live ALU result.
  always_comb begin
    next_state = state;
    imrd_c     = 1'b0;
    irwr_c     = 1'b0;
    pcwr_c     = 1'b0;
    ruwr_c     = 1'b0;
    dmrd_c     = 1'b0;
    dmwr_c     = 1'b0;
    dmctrl_c   = 3'b000;
    rusrc_c    = WB_ALU;
    brop_c     = BR_NONE;
    alu_en     = 1'b0;
    wait_inc   = 1'b0;
    trap_set   = 1'b0;
    trap_code  = 2'b00;
    case (state)
      S_FETCH: begin
        imrd_c = 1'b1;
        if (InstrReady) begin
          irwr_c     = 1'b1;
          next_state = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_TRAP;
          trap_set   = 1'b1;
          trap_code  = CAUSE_FETCH;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal(OpCode)) begin
          next_state = S_EXEC;
        end else begin
          next_state = S_TRAP;
          trap_set   = 1'b1;
          trap_code  = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (is_branch) begin
          brop_c     = {2'b01, funct3_q};
          pcwr_c     = 1'b1;
          next_state = S_FETCH;
        end else if (is_load || is_store) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        alu_en   = 1'b1;
        dmrd_c   = is_load;
        dmwr_c   = is_store;
        dmctrl_c = funct3_q;
        if (MemReady) begin
          if (is_load) begin
            next_state = S_WB;
          end else begin
            pcwr_c     = 1'b1;
            next_state = S_FETCH;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_TRAP;
          trap_set   = 1'b1;
          trap_code  = CAUSE_MEM;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        alu_en     = 1'b1;
        ruwr_c     = 1'b1;
        pcwr_c     = 1'b1;
        next_state = S_FETCH;
        if (is_load)      rusrc_c = WB_MEM;
        else if (is_jump) rusrc_c = WB_PC4;
        if (is_jump)      brop_c  = BR_JUMP;
      end
      S_TRAP: ;
      default: next_state = S_FETCH;
    endcase
  end

  // Output drive; reset forces every strobe and encoding low immediately.
  always_comb begin
    IMRd        = 1'b0;
    IRWr        = 1'b0;
    PCWr        = 1'b0;
    RUWr        = 1'b0;
    ALUASrc     = 1'b0;
    ALUBSrc     = 1'b0;
    ALUOp       = 4'b0000;
    ImmSrc      = 3'b000;
    BrOp        = BR_NONE;
    DMRd        = 1'b0;
    DMWr        = 1'b0;
    DMCtrl      = 3'b000;
    RUDataWrSrc = WB_ALU;
    if (rst_n) begin
      IMRd        = imrd_c;
      IRWr        = irwr_c;
      PCWr        = pcwr_c;
      RUWr        = ruwr_c;
      ALUASrc     = alu_en & alu_a_c;
      ALUBSrc     = alu_en & alu_b_c;
      ALUOp       = alu_en ? alu_op_c : 4'b0000;
      ImmSrc      = alu_en ? imm_c : 3'b000;
      BrOp        = brop_c;
      DMRd        = dmrd_c;
      DMWr        = dmwr_c;
      DMCtrl      = dmctrl_c;
      RUDataWrSrc = rusrc_c;
    end
  end

  assign State     = state;
  assign Trap      = (state == S_TRAP);
  assign TrapCause = cause_q;
  assign InstRet   = inst_ret_q;

  // State, wait counter, latched fields, trap cause and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7_5_q <= 1'b0;
      cause_q    <= 2'b00;
      inst_ret_q <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) wait_cnt <= '0;
      else if (wait_inc)       wait_cnt <= wait_cnt + TW'(1);
      if (state == S_DECODE) begin
        opcode_q   <= OpCode;
        funct3_q   <= Funct3;
        funct7_5_q <= Funct7[5];
      end
      if (trap_set) cause_q    <= trap_code;
      if (pcwr_c)   inst_ret_q <= inst_ret_q + CNT_W'(1);
    end
  end

endmodule
